// File: rtl/cm_sketch_topk_reader.sv
`default_nettype none
// ============================================================================
// Module   : cm_sketch_topk_reader
// Brief    : Walks the descending-count CAM from index 0 and streams the top
//            {addr, cnt, rank} records over valid/ready, stopping early on an
//            empty entry or a count below the latched threshold.
//            Optional macro CM_TOPK_CLEAR_EN adds a one-cycle CAM clear request
//            at the end of every query.
// Revision : 1.0 - initial release
// ============================================================================
module cm_sketch_topk_reader #(
    parameter int ADDR_SIZE  = 22,
    parameter int CNT_SIZE   = 32,
    parameter int NUM_ENTRY  = 25,
    parameter int INDEX_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  query_req,
    input  logic [INDEX_SIZE-1:0] query_num,
    input  logic [CNT_SIZE-1:0]   min_cnt,
    output logic                  query_busy,
    output logic                  cam_freeze,
    output logic                  cam_rd_en,
    output logic [INDEX_SIZE-1:0] cam_rd_idx,
    input  logic                  cam_rd_vld,
    input  logic [ADDR_SIZE-1:0]  cam_rd_addr,
    input  logic [CNT_SIZE-1:0]   cam_rd_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [CNT_SIZE-1:0]   out_cnt,
    output logic [INDEX_SIZE-1:0] out_rank,
    output logic                  query_done,
    output logic [INDEX_SIZE:0]   query_count,
    output logic                  cam_clear
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef CM_TOPK_CLEAR_EN
    localparam logic [2:0] ST_CLEAR = 3'd5;
    localparam logic [2:0] ST_TERM  = ST_CLEAR;
`else
    localparam logic [2:0] ST_TERM  = ST_DONE;
`endif

    localparam logic [INDEX_SIZE:0]   C_NUM_ENTRY = (INDEX_SIZE + 1)'(NUM_ENTRY);
    localparam logic [INDEX_SIZE-1:0] C_LAST_IDX  = INDEX_SIZE'(NUM_ENTRY - 1);

    logic [2:0]            state_q,    state_d;
    logic [INDEX_SIZE-1:0] idx_q,      idx_d;
    logic [INDEX_SIZE:0]   emitted_q,  emitted_d;
    logic [INDEX_SIZE:0]   num_q,      num_d;
    logic [CNT_SIZE-1:0]   thr_q,      thr_d;
    logic [ADDR_SIZE-1:0]  out_addr_q, out_addr_d;
    logic [CNT_SIZE-1:0]   out_cnt_q,  out_cnt_d;
    logic [INDEX_SIZE-1:0] out_rank_q, out_rank_d;

    logic [INDEX_SIZE:0]   w_query_num_ext;
    logic [INDEX_SIZE:0]   w_emitted_inc;

    assign w_query_num_ext = {1'b0, query_num};
    assign w_emitted_inc   = emitted_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        emitted_d  = emitted_q;
        num_d      = num_q;
        thr_d      = thr_q;
        out_addr_d = out_addr_q;
        out_cnt_d  = out_cnt_q;
        out_rank_d = out_rank_q;

        case (state_q)
            ST_IDLE: begin
                if (query_req) begin
                    // Request size and threshold are frozen for the whole query.
                    num_d     = (w_query_num_ext > C_NUM_ENTRY) ? C_NUM_ENTRY : w_query_num_ext;
                    thr_d     = min_cnt;
                    idx_d     = '0;
                    emitted_d = '0;
                    state_d   = (query_num == '0) ? ST_TERM : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cam_rd_vld || (cam_rd_cnt < thr_q)) begin
                    state_d = ST_TERM;
                end else begin
                    out_addr_d = cam_rd_addr;
                    out_cnt_d  = cam_rd_cnt;
                    out_rank_d = idx_q;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    emitted_d = w_emitted_inc;
                    // Index saturates at the last entry so it can never wrap.
                    if ((w_emitted_inc == num_q) || (idx_q == C_LAST_IDX)) begin
                        state_d = ST_TERM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
`ifdef CM_TOPK_CLEAR_EN
            ST_CLEAR: begin
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            emitted_q  <= '0;
            num_q      <= '0;
            thr_q      <= '0;
            out_addr_q <= '0;
            out_cnt_q  <= '0;
            out_rank_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            emitted_q  <= emitted_d;
            num_q      <= num_d;
            thr_q      <= thr_d;
            out_addr_q <= out_addr_d;
            out_cnt_q  <= out_cnt_d;
            out_rank_q <= out_rank_d;
        end
    end

    assign query_busy  = (state_q != ST_IDLE);
    assign cam_freeze  = query_busy;
    assign cam_rd_en   = (state_q == ST_READ);
    assign cam_rd_idx  = idx_q;
    assign out_valid   = (state_q == ST_EMIT);
    assign out_addr    = out_addr_q;
    assign out_cnt     = out_cnt_q;
    assign out_rank    = out_rank_q;
    assign query_done  = (state_q == ST_DONE);
    assign query_count = emitted_q;

`ifdef CM_TOPK_CLEAR_EN
    assign cam_clear = (state_q == ST_CLEAR);
`else
    assign cam_clear = 1'b0;
`endif

endmodule
`default_nettype wire
